// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth calculation, threshold range checks and read-mode constants.
// Threshold check macros are defined here so every FIFO variant validates parameters identically.
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_AF_OK(af, depth) (((af) >= 1) && ((af) <= (depth)))
`define FIFO_AE_OK(ae, depth) (((ae) >= 0) && ((ae) <= ((depth) - 1)))
`endif

package fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous (zero-latency) read port.
// No reset on the array; no flow control, the owner gates wr_en.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO, standard (1-cycle registered read) or first-word-fall-through (0-cycle) read.
// Backpressure: writes dropped while full and reads ignored while empty, each latching a sticky error.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("sync_fifo_fwft: ADDR_WIDTH must be >= 1");
  end
  if (!`FIFO_AF_OK(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("sync_fifo_fwft: AF_THRESH out of range 1..DEPTH");
  end
  if (!`FIFO_AE_OK(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Gated to zero while empty so the output is defined before any word is written.
    assign rd_data  = empty ? '0 : mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rv_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else if (flush) begin
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) rd_q <= mem_rdata;
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rv_q;
  end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives one stimulus stream into a standard and an FWFT instance; a queue model checks both every cycle.
module tb_sync_fifo_fwft;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [3:0] s_count, f_count;
  logic       s_ov, f_ov, s_un, f_un;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(FIFO_STD)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_un)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: contents as a queue, plus the standard-mode read register and sticky errors.
  logic [7:0] q[$];
  logic       m_ov, m_un, m_rv;
  logic [7:0] m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
    end else if (flush) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == 8);
      automatic bit was_empty = (q.size() == 0);
      m_rv = rd_en && !was_empty;
      if (m_rv) m_rd = q.pop_front();
      if (wr_en && !was_full) q.push_back(wr_data);
      if (wr_en && was_full) m_ov = 1'b1;
      if (rd_en && was_empty) m_un = 1'b1;
    end
  end

  always @(negedge clk) begin
    automatic int n = q.size();
    check("std_count", 32'(s_count), 32'(n));
    check("std_full", 32'(s_full), 32'(n == 8));
    check("std_empty", 32'(s_empty), 32'(n == 0));
    check("std_af", 32'(s_af), 32'(n >= 6));
    check("std_ae", 32'(s_ae), 32'(n <= 2));
    check("std_ov", 32'(s_ov), 32'(m_ov));
    check("std_un", 32'(s_un), 32'(m_un));
    check("std_rd_valid", 32'(s_rd_valid), 32'(m_rv));
    check("std_rd_data", 32'(s_rd_data), 32'(m_rd));
    check("fwft_count", 32'(f_count), 32'(n));
    check("fwft_full", 32'(f_full), 32'(n == 8));
    check("fwft_empty", 32'(f_empty), 32'(n == 0));
    check("fwft_af", 32'(f_af), 32'(n >= 6));
    check("fwft_ae", 32'(f_ae), 32'(n <= 2));
    check("fwft_ov", 32'(f_ov), 32'(m_ov));
    check("fwft_un", 32'(f_un), 32'(m_un));
    check("fwft_rd_valid", 32'(f_rd_valid), 32'(n != 0));
    check("fwft_rd_data", 32'(f_rd_data), 32'((n != 0) ? q[0] : 8'h00));
  end

  // Apply one cycle of inputs, return 1 time unit after the edge with inputs idle.
  task automatic step(input logic f, input logic we, input logic [7:0] wd, input logic re);
    flush = f; wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    #1;
    flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_ae", 32'(s_ae), 32'd1);
    check("rst_full", 32'(s_full), 32'd0);
    check("rst_ov", 32'(s_ov), 32'd0);
    check("rst_rd_data", 32'(s_rd_data), 32'h00);
    check("rst_fwft_rd_data", 32'(f_rd_data), 32'h00);
    check("rst_fwft_valid", 32'(f_rd_valid), 32'd0);

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 5) check("af_at5", 32'(s_af), 32'd0);
      if (i == 6) check("af_at6", 32'(s_af), 32'd1);
      if (i == 7) check("full_at7", 32'(s_full), 32'd0);
    end
    check("full_at8", 32'(s_full), 32'd1);
    check("fwft_head_01", 32'(f_rd_data), 32'h01);

    step(1'b0, 1'b1, 8'hAA, 1'b0);
    check("ovf_flag", 32'(s_ov), 32'd1);
    check("ovf_count", 32'(s_count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      check("fwft_drain_head", 32'(f_rd_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("std_drain_data", 32'(s_rd_data), 32'(i));
      check("std_drain_valid", 32'(s_rd_valid), 32'd1);
    end
    check("drain_empty", 32'(s_empty), 32'd1);

    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("unf_flag", 32'(s_un), 32'd1);
    check("unf_valid", 32'(s_rd_valid), 32'd0);
    check("unf_hold", 32'(s_rd_data), 32'h08);

    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 8'(8'h14 + k), 1'b1);
      check("wrap_count", 32'(s_count), 32'd4);
    end
    check("wrap_std_last", 32'(s_rd_data), 32'h23);
    check("wrap_fwft_head", 32'(f_rd_data), 32'h24);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("pre_flush_count", 32'(s_count), 32'd5);
    check("pre_flush_ov", 32'(s_ov), 32'd1);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("flush_count", 32'(s_count), 32'd0);
    check("flush_empty", 32'(f_empty), 32'd1);
    check("flush_ov", 32'(f_ov), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("flush_drop", 32'(f_count), 32'd0);

    step(1'b0, 1'b1, 8'h5C, 1'b0);
    check("fwft_lat_data", 32'(f_rd_data), 32'h5C);
    check("fwft_lat_valid", 32'(f_rd_valid), 32'd1);
    check("std_lat_valid", 32'(s_rd_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);
    check("std_pop_data", 32'(s_rd_data), 32'h5C);

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    check("midrst_af_before", 32'(s_af), 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE; rst_n = 1'b0;
    #2;
    check("midrst_count", 32'(s_count), 32'd0);
    check("midrst_af", 32'(f_af), 32'd0);
    check("midrst_empty", 32'(f_empty), 32'd1);
    check("midrst_std_valid", 32'(s_rd_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
